// File: rtl/reg_dump_if.sv
// reg_dump_if: valid/ready stream carrying dumped register words and their indices.
interface reg_dump_if #(
   parameter int SEL_BITS = 3,
   parameter int BIT_SIZE = 16
);
   logic [BIT_SIZE-1:0] out_data;
   logic [SEL_BITS-1:0] out_index;
   logic                out_valid;
   logic                out_ready;
   logic                out_last;
   modport master (output out_data, out_index, out_valid, out_last, input out_ready);
   modport slave (input out_data, out_index, out_valid, out_last, output out_ready);
endinterface

// File: rtl/reg_dump.sv
// reg_dump: walks a register file read port and streams every register out over a valid/ready link.
// Optional REG_DUMP_CHECKSUM_EN appends an XOR checksum word after the last register.
module reg_dump #(
   parameter int SEL_BITS = 3,
   parameter int BIT_SIZE = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic [SEL_BITS-1:0] sel,
   input  logic [BIT_SIZE-1:0] rd_data,
   reg_dump_if.master          dump,
   output logic                busy,
   output logic                done
);
   localparam logic [SEL_BITS-1:0] LAST_SEL = '1;
`ifdef REG_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, READ, SEND, FIN, CHK} state_t;
   logic [BIT_SIZE-1:0] sum_q, sum_n;
`else
   typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;
`endif
   state_t state, state_n;
   logic [SEL_BITS-1:0] sel_n, index_q, index_n;
   logic [BIT_SIZE-1:0] data_q, data_n;
   logic valid_q, valid_n, last_q, last_n, accept;
   assign accept = valid_q && dump.out_ready;
   assign busy = state != IDLE;
   assign done = state == FIN;
   assign dump.out_data = data_q;
   assign dump.out_index = index_q;
   assign dump.out_valid = valid_q;
   assign dump.out_last = last_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sel <= '0;
         data_q <= '0;
         index_q <= '0;
         valid_q <= 1'b0;
         last_q <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
         sum_q <= '0;
`endif
      end else begin
         sel <= sel_n;
         data_q <= data_n;
         index_q <= index_n;
         valid_q <= valid_n;
         last_q <= last_n;
`ifdef REG_DUMP_CHECKSUM_EN
         sum_q <= sum_n;
`endif
      end
   always_comb begin
      state_n = state;
      sel_n = sel;
      data_n = data_q;
      index_n = index_q;
      valid_n = valid_q;
      last_n = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
      sum_n = sum_q;
`endif
      case (state)
         IDLE: if (start) begin
            state_n = READ;
            sel_n = '0;
`ifdef REG_DUMP_CHECKSUM_EN
            sum_n = '0;
`endif
         end
         READ: begin
            state_n = SEND;
            data_n = rd_data;
            index_n = sel;
            valid_n = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            last_n = 1'b0;
`else
            last_n = sel == LAST_SEL;
`endif
         end
         SEND: if (accept) begin
            valid_n = 1'b0;
            last_n = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            sum_n = sum_q ^ data_q;
`endif
            // sel saturates on the final register instead of wrapping to 0
            if (index_q == LAST_SEL) begin
`ifdef REG_DUMP_CHECKSUM_EN
               state_n = CHK;
`else
               state_n = FIN;
`endif
            end else begin
               sel_n = sel + 1'b1;
               state_n = READ;
            end
         end
`ifdef REG_DUMP_CHECKSUM_EN
         // first CHK cycle loads the finished checksum, later cycles wait for the handshake
         CHK: if (!valid_q) begin
            data_n = sum_q;
            index_n = '0;
            valid_n = 1'b1;
            last_n = 1'b1;
         end else if (dump.out_ready) begin
            valid_n = 1'b0;
            last_n = 1'b0;
            state_n = FIN;
         end
`endif
         FIN: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: table-driven and randomized checks of reg_dump against a word-sequence model.
module tb_reg_dump;
   localparam int SB = 3;
   localparam int BS = 16;
   localparam int N = 1 << SB;
`ifdef REG_DUMP_CHECKSUM_EN
   localparam int NW = N + 1;
   localparam int EXTRA = 2;
`else
   localparam int NW = N;
   localparam int EXTRA = 0;
`endif
   typedef struct {int mode; bit hold; int exp_lat;} vec_t;
   logic clk = 0;
   logic reset = 0;
   logic start = 0;
   logic busy, done;
   logic [SB-1:0] sel;
   logic [BS-1:0] rd_data;
   logic [BS-1:0] regs [N];
   int n_cmp = 0;
   int n_bad = 0;
   vec_t vecs [5];
   reg_dump_if #(.SEL_BITS(SB), .BIT_SIZE(BS)) dif ();
   reg_dump #(.SEL_BITS(SB), .BIT_SIZE(BS)) dut (
      .clk(clk), .reset(reset), .start(start), .sel(sel), .rd_data(rd_data),
      .dump(dif.master), .busy(busy), .done(done)
   );
   assign rd_data = regs[sel];
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // mode: 0 ready high, 1 ready toggles, 2 ready low 5 cycles on index 3, 3 random ready
   task automatic run_dump(input int mode, input bit hold, input int exp_lat);
      int k = 0, cyc = 0, stalls = 0, sc = 0, lat = 0;
      bit got = 0, held = 0;
      logic [BS-1:0] hd, x = '0;
      logic [SB-1:0] hi;
      logic hl;
      @(negedge clk);
      start = 1;
      dif.out_ready = mode != 1;
      while (!got && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (!hold) start = 0;
         if (held) begin
            check("valid_held", dif.out_valid, 1);
            check("data_stable", dif.out_data, hd);
            check("index_stable", dif.out_index, hi);
            check("last_stable", dif.out_last, hl);
         end
         case (mode)
            0: dif.out_ready = 1;
            1: dif.out_ready = ~dif.out_ready;
            2: begin
               dif.out_ready = !(dif.out_valid && dif.out_index == 3 && sc < 5);
               if (!dif.out_ready) sc++;
            end
            default: dif.out_ready = 1'($urandom_range(0, 1));
         endcase
         held = dif.out_valid && !dif.out_ready;
         if (held) begin
            stalls++;
            hd = dif.out_data;
            hi = dif.out_index;
            hl = dif.out_last;
         end
         if (dif.out_valid && dif.out_ready) begin
            if (k < N) begin
               check("word_data", dif.out_data, regs[k]);
               check("word_index", dif.out_index, k);
               check("word_last", dif.out_last, k == NW - 1);
               check("sel_tracks", sel, k);
               x ^= regs[k];
            end else begin
               check("sum_data", dif.out_data, x);
               check("sum_index", dif.out_index, 0);
               check("sum_last", dif.out_last, 1);
            end
            k++;
         end
         check("busy_in_dump", busy, 1);
         if (done) begin
            got = 1;
            lat = cyc - 1;
            check("valid_at_done", dif.out_valid, 0);
         end
      end
      check("done_seen", got, 1);
      check("word_count", k, NW);
      check("latency_model", lat, 2 * N + EXTRA + stalls);
      if (exp_lat != 0) check("latency_table", lat, exp_lat);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);
      @(negedge clk);
      check("restart", busy, hold);
      if (hold) begin
         start = 0;
         dif.out_ready = 1;
         got = 0;
         for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = done;
         end
         check("drain_done", got, 1);
         @(negedge clk);
      end
   endtask
   initial begin
      bit found;
      vecs[0] = '{0, 0, 16};
      vecs[1] = '{2, 0, 21};
      vecs[2] = '{1, 0, 0};
      vecs[3] = '{0, 1, 16};
      vecs[4] = '{3, 0, 0};
      for (int i = 0; i < N; i++) regs[i] = 16'h1000 + 16'(i);
      dif.out_ready = 0;
      repeat (2) @(negedge clk);
      check("rst_valid", dif.out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_data", dif.out_data, 0);
      check("rst_index", dif.out_index, 0);
      check("rst_last", dif.out_last, 0);
      check("rst_sel", sel, 0);
      reset = 1;
      for (int i = 0; i < 5; i++)
         run_dump(vecs[i].mode, vecs[i].hold, vecs[i].exp_lat != 0 ? vecs[i].exp_lat + EXTRA : 0);
      // abort a dump while index 4 is pending
      @(negedge clk);
      start = 1;
      dif.out_ready = 1;
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         start = 0;
         if (dif.out_valid && dif.out_index == 4) begin
            dif.out_ready = 0;
            found = 1;
         end
      end
      check("idx4_seen", found, 1);
      @(negedge clk);
      #2 reset = 0;
      #1;
      check("abort_valid", dif.out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_index", dif.out_index, 0);
      check("abort_data", dif.out_data, 0);
      check("abort_sel", sel, 0);
      @(negedge clk);
      reset = 1;
      dif.out_ready = 1;
      repeat (3) begin
         @(negedge clk);
         check("no_resume_busy", busy, 0);
         check("no_resume_valid", dif.out_valid, 0);
      end
      run_dump(0, 0, 16 + EXTRA);
      repeat (6) begin
         for (int i = 0; i < N; i++) regs[i] = 16'($urandom);
         run_dump(3, 0, 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
